// File: rtl/sdram_bank_pkg.sv
// sdram_bank_pkg: shared types and latency defaults for the per-bank DRAM timer.
// Optional refresh support is selected with `define SDRAM_BANK_REFRESH_EN.
package sdram_bank_pkg;

    typedef enum logic [1:0] {
        BANK_IDLE        = 2'd0,
        BANK_ACTIVATING  = 2'd1,
        BANK_ACTIVE      = 2'd2,
        BANK_PRECHARGING = 2'd3
    } bank_state_e;

    typedef enum logic [1:0] {
        CMD_ACT  = 2'd0,
        CMD_PRE  = 2'd1,
        CMD_PREA = 2'd2,
        CMD_REF  = 2'd3
    } cmd_op_e;

    localparam int DEF_ROW_WIDTH       = 14;
    localparam int DEF_NUM_GROUPS      = 2;
    localparam int DEF_BANKS_PER_GROUP = 4;
    localparam int DEF_T_RCD           = 4;
    localparam int DEF_T_RP            = 3;
    localparam int DEF_T_RAS           = 8;
    localparam int DEF_T_RRD           = 2;
    localparam int DEF_T_RFC           = 10;

    function automatic int max5(input int a, input int b, input int c, input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    // Bits needed to hold values 0..max_lat, never less than one.
    function automatic int cnt_width(input int max_lat);
        return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/sdram_bank_fsm.sv
// sdram_bank_fsm: one DRAM bank. Holds the bank state, the tRCD/tRP/tRFC phase
// counter, the tRAS counter and the row opened by the last ACT.
// A refresh (only ever requested when SDRAM_BANK_REFRESH_EN is defined) is
// reported with the PRECHARGING code: both are timed busy phases that end in
// IDLE and block every command, and the state port is only two bits wide.
module sdram_bank_fsm
    import sdram_bank_pkg::*;
#(
    parameter int ROW_WIDTH = DEF_ROW_WIDTH,
    parameter int CNT_W     = 4,
    parameter int T_RCD     = DEF_T_RCD,
    parameter int T_RP      = DEF_T_RP,
    parameter int T_RAS     = DEF_T_RAS,
    parameter int T_RFC     = DEF_T_RFC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 do_act,
    input  logic                 do_pre,
    input  logic                 do_ref,
    input  logic [ROW_WIDTH-1:0] row,
    output bank_state_e          state,
    output logic [ROW_WIDTH-1:0] open_row,
    output logic                 ras_done
);

    logic [CNT_W-1:0] main_cnt;
    logic [CNT_W-1:0] ras_cnt;

    assign ras_done = (ras_cnt == '0);

    // Bank FSM: a timed phase ends on the edge where its counter reaches zero,
    // so ACTIVATING/PRECHARGING are visible for T-1 cycles after the command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BANK_IDLE;
            main_cnt <= '0;
            ras_cnt  <= '0;
            open_row <= '0;
        end else begin
            if (ras_cnt != '0) ras_cnt <= ras_cnt - CNT_W'(1);
            if (do_act) begin
                open_row <= row;
                ras_cnt  <= CNT_W'(T_RAS - 1);
                main_cnt <= CNT_W'(T_RCD - 1);
                state    <= (T_RCD > 1) ? BANK_ACTIVATING : BANK_ACTIVE;
            end else if (do_pre) begin
                main_cnt <= CNT_W'(T_RP - 1);
                state    <= (T_RP > 1) ? BANK_PRECHARGING : BANK_IDLE;
            end else if (do_ref) begin
                main_cnt <= CNT_W'(T_RFC - 1);
                state    <= (T_RFC > 1) ? BANK_PRECHARGING : BANK_IDLE;
            end else begin
                if (main_cnt != '0) main_cnt <= main_cnt - CNT_W'(1);
                if (main_cnt <= CNT_W'(1)) begin
                    case (state)
                        BANK_ACTIVATING:  state <= BANK_ACTIVE;
                        BANK_PRECHARGING: state <= BANK_IDLE;
                        default:          state <= state;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/sdram_bank_timer.sv
// sdram_bank_timer: per-bank DRAM state/timing tracker. Checks ACT/PRE/PREA/REF
// against the bank FSMs and the tRRD timer and publishes open rows and
// legality flags to the scheduler. REF is supported only when the macro
// SDRAM_BANK_REFRESH_EN is defined; otherwise REF is always illegal.
module sdram_bank_timer
    import sdram_bank_pkg::*;
#(
    parameter int  ROW_WIDTH       = DEF_ROW_WIDTH,
    parameter int  NUM_GROUPS      = DEF_NUM_GROUPS,
    parameter int  BANKS_PER_GROUP = DEF_BANKS_PER_GROUP,
    localparam int BANKS           = NUM_GROUPS * BANKS_PER_GROUP,
    parameter int  BANK_IDX_W      = (BANKS > 1) ? $clog2(BANKS) : 1,
    parameter int  T_RCD           = DEF_T_RCD,
    parameter int  T_RP            = DEF_T_RP,
    parameter int  T_RAS           = DEF_T_RAS,
    parameter int  T_RRD           = DEF_T_RRD,
    parameter int  T_RFC           = DEF_T_RFC
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    input  logic [1:0]                      cmd_op,
    input  logic [BANK_IDX_W-1:0]           cmd_bank,
    input  logic [ROW_WIDTH-1:0]            cmd_row,
    output logic                            cmd_legal,
    output logic                            cmd_err,
    output logic [BANKS-1:0][1:0]           bank_state,
    output logic [BANKS-1:0][ROW_WIDTH-1:0] open_row,
    output logic [BANKS-1:0]                can_access,
    output logic [BANKS-1:0]                can_activate,
    output logic [BANKS-1:0]                can_precharge
);

`ifdef SDRAM_BANK_REFRESH_EN
    localparam int MAX_LAT = max5(T_RCD, T_RP, T_RAS, T_RRD, T_RFC);
`else
    localparam int MAX_LAT = max5(T_RCD, T_RP, T_RAS, T_RRD, 1);
`endif
    localparam int CNT_W = cnt_width(MAX_LAT);

    cmd_op_e          op;
    logic [CNT_W-1:0] rrd_cnt;
    logic             rrd_done;
    bank_state_e      st [BANKS];
    logic [BANKS-1:0] ras_done;
    logic [BANKS-1:0] do_act;
    logic [BANKS-1:0] do_pre;
    logic [BANKS-1:0] do_ref;
    logic             tgt_hit;
    bank_state_e      tgt_state;
    logic             tgt_ras_done;
    logic             legal_prea;
    logic             legal_ref;
    logic             accept;

    assign op       = cmd_op_e'(cmd_op);
    assign rrd_done = (rrd_cnt == '0);
    assign accept   = cmd_valid & cmd_legal;

    // Addressed-bank lookup; an index at or beyond BANKS matches no bank.
    always_comb begin
        tgt_hit      = 1'b0;
        tgt_state    = BANK_IDLE;
        tgt_ras_done = 1'b0;
        for (int unsigned i = 0; i < BANKS; i++) begin
            if (cmd_bank == BANK_IDX_W'(i)) begin
                tgt_hit      = 1'b1;
                tgt_state    = st[i];
                tgt_ras_done = ras_done[i];
            end
        end
    end

    // PREA needs every bank settled and every open bank past tRAS.
    always_comb begin
        legal_prea = 1'b1;
        for (int unsigned i = 0; i < BANKS; i++) begin
            if (st[i] == BANK_ACTIVATING || st[i] == BANK_PRECHARGING) legal_prea = 1'b0;
            if (st[i] == BANK_ACTIVE && !ras_done[i]) legal_prea = 1'b0;
        end
    end

`ifdef SDRAM_BANK_REFRESH_EN
    // REF needs every bank idle and the tRRD window closed.
    always_comb begin
        legal_ref = rrd_done;
        for (int unsigned i = 0; i < BANKS; i++) begin
            if (st[i] != BANK_IDLE) legal_ref = 1'b0;
        end
    end
`else
    assign legal_ref = 1'b0;
`endif

    // Legality decode from registered state and the command fields only.
    always_comb begin
        cmd_legal = 1'b0;
        case (op)
            CMD_ACT:  cmd_legal = tgt_hit && (tgt_state == BANK_IDLE) && rrd_done;
            CMD_PRE:  cmd_legal = tgt_hit && (tgt_state == BANK_ACTIVE) && tgt_ras_done;
            CMD_PREA: cmd_legal = legal_prea;
            CMD_REF:  cmd_legal = legal_ref;
            default:  cmd_legal = 1'b0;
        endcase
    end

    // Per-bank command strobes for an accepted command.
    always_comb begin
        do_act = '0;
        do_pre = '0;
        do_ref = '0;
        for (int unsigned i = 0; i < BANKS; i++) begin
            if (accept) begin
                do_act[i] = (op == CMD_ACT) && (cmd_bank == BANK_IDX_W'(i));
                do_pre[i] = ((op == CMD_PRE) && (cmd_bank == BANK_IDX_W'(i)))
                         || ((op == CMD_PREA) && (st[i] == BANK_ACTIVE));
                do_ref[i] = (op == CMD_REF);
            end
        end
    end

    // tRRD window shared by all banks, restarted by each accepted ACT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrd_cnt <= '0;
        end else if (accept && op == CMD_ACT) begin
            rrd_cnt <= CNT_W'(T_RRD - 1);
        end else if (rrd_cnt != '0) begin
            rrd_cnt <= rrd_cnt - CNT_W'(1);
        end
    end

    // One-cycle error pulse following any rejected command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cmd_err <= 1'b0;
        else     cmd_err <= cmd_valid & ~cmd_legal;
    end

    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        sdram_bank_fsm #(
            .ROW_WIDTH (ROW_WIDTH),
            .CNT_W     (CNT_W),
            .T_RCD     (T_RCD),
            .T_RP      (T_RP),
            .T_RAS     (T_RAS),
            .T_RFC     (T_RFC)
        ) u_fsm (
            .clk      (clk),
            .rst      (rst),
            .do_act   (do_act[g]),
            .do_pre   (do_pre[g]),
            .do_ref   (do_ref[g]),
            .row      (cmd_row),
            .state    (st[g]),
            .open_row (open_row[g]),
            .ras_done (ras_done[g])
        );
    end

    // Scheduler-facing status flags per bank.
    always_comb begin
        for (int unsigned i = 0; i < BANKS; i++) begin
            bank_state[i]    = st[i];
            can_access[i]    = (st[i] == BANK_ACTIVE);
            can_activate[i]  = (st[i] == BANK_IDLE) && rrd_done;
            can_precharge[i] = (st[i] == BANK_ACTIVE) && ras_done[i];
        end
    end

endmodule

// File: tb/tb_sdram_bank_timer.sv
// tb_sdram_bank_timer: directed table, corner sequences and random traffic for
// sdram_bank_timer, checked against a timestamp-based reference model.
module tb_sdram_bank_timer;

    localparam int NB    = 8;
    localparam int T_RCD = 4;
    localparam int T_RP  = 3;
    localparam int T_RAS = 8;
    localparam int T_RRD = 2;
    localparam int T_RFC = 10;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACTG = 2'd1;
    localparam logic [1:0] S_ACT  = 2'd2;
    localparam logic [1:0] S_PRE  = 2'd3;

    localparam logic [1:0] OP_ACT  = 2'd0;
    localparam logic [1:0] OP_PRE  = 2'd1;
    localparam logic [1:0] OP_PREA = 2'd2;
    localparam logic [1:0] OP_REF  = 2'd3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cmd_valid;
    logic [1:0]           cmd_op;
    logic [2:0]           cmd_bank;
    logic [13:0]          cmd_row;
    logic                 cmd_legal;
    logic                 cmd_err;
    logic [NB-1:0][1:0]   bank_state;
    logic [NB-1:0][13:0]  open_row;
    logic [NB-1:0]        can_access;
    logic [NB-1:0]        can_activate;
    logic [NB-1:0]        can_precharge;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sdram_bank_timer dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_op        (cmd_op),
        .cmd_bank      (cmd_bank),
        .cmd_row       (cmd_row),
        .cmd_legal     (cmd_legal),
        .cmd_err       (cmd_err),
        .bank_state    (bank_state),
        .open_row      (open_row),
        .can_access    (can_access),
        .can_activate  (can_activate),
        .can_precharge (can_precharge)
    );

    // Reference model: each bank remembers its last event kind and the cycle
    // the command was presented; everything else is derived from elapsed time.
    longint      cyc;
    int          m_kind [NB];   // 0 none, 1 ACT, 2 PRE, 3 REF
    longint      m_ev   [NB];
    longint      m_act  [NB];
    longint      m_last_act;
    logic [13:0] m_row  [NB];
    logic        m_err;

    function automatic logic [1:0] m_state(input int b);
        longint age;
        age = cyc - m_ev[b];
        case (m_kind[b])
            1:       return (age < T_RCD) ? S_ACTG : S_ACT;
            2:       return (age < T_RP)  ? S_PRE  : S_IDLE;
            3:       return (age < T_RFC) ? S_PRE  : S_IDLE;
            default: return S_IDLE;
        endcase
    endfunction

    function automatic logic m_ras_ok(input int b);
        return (cyc - m_act[b]) >= T_RAS;
    endfunction

    function automatic logic m_rrd_ok();
        return (cyc - m_last_act) >= T_RRD;
    endfunction

    function automatic logic m_legal(input logic [1:0] op, input int b);
        logic ok;
        case (op)
            OP_ACT: return (m_state(b) == S_IDLE) && m_rrd_ok();
            OP_PRE: return (m_state(b) == S_ACT) && m_ras_ok(b);
            OP_PREA: begin
                ok = 1'b1;
                for (int k = 0; k < NB; k++) begin
                    if (m_state(k) == S_ACTG || m_state(k) == S_PRE) ok = 1'b0;
                    if (m_state(k) == S_ACT && !m_ras_ok(k)) ok = 1'b0;
                end
                return ok;
            end
            default: begin
`ifdef SDRAM_BANK_REFRESH_EN
                ok = m_rrd_ok();
                for (int k = 0; k < NB; k++) if (m_state(k) != S_IDLE) ok = 1'b0;
                return ok;
`else
                return 1'b0;
`endif
            end
        endcase
    endfunction

    task automatic m_reset();
        for (int k = 0; k < NB; k++) begin
            m_kind[k] = 0;
            m_ev[k]   = -1000;
            m_act[k]  = -1000;
            m_row[k]  = '0;
        end
        m_last_act = -1000;
        m_err      = 1'b0;
        cyc        = 0;
    endtask

    task automatic m_apply(input logic [1:0] op, input int b, input logic [13:0] row);
        logic [1:0] snap [NB];
        for (int k = 0; k < NB; k++) snap[k] = m_state(k);
        case (op)
            OP_ACT: begin
                m_kind[b] = 1; m_ev[b] = cyc; m_act[b] = cyc;
                m_last_act = cyc; m_row[b] = row;
            end
            OP_PRE: begin
                m_kind[b] = 2; m_ev[b] = cyc;
            end
            OP_PREA: begin
                for (int k = 0; k < NB; k++)
                    if (snap[k] == S_ACT) begin m_kind[k] = 2; m_ev[k] = cyc; end
            end
            default: begin
                for (int k = 0; k < NB; k++) begin m_kind[k] = 3; m_ev[k] = cyc; end
            end
        endcase
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        logic [15:0]   es;
        logic [NB-1:0] ea, eact, epre;
        for (int b = 0; b < NB; b++) begin
            es[2*b +: 2] = m_state(b);
            ea[b]   = (m_state(b) == S_ACT);
            eact[b] = (m_state(b) == S_IDLE) && m_rrd_ok();
            epre[b] = (m_state(b) == S_ACT) && m_ras_ok(b);
        end
        chk("legal", cmd_legal, m_legal(cmd_op, int'(cmd_bank)));
        chk("err", cmd_err, m_err);
        chk("bank_state", bank_state, es);
        chk("can_access", can_access, ea);
        chk("can_activate", can_activate, eact);
        chk("can_precharge", can_precharge, epre);
        for (int b = 0; b < NB; b++) chk($sformatf("open_row%0d", b), open_row[b], m_row[b]);
    endtask

    // Inputs are driven 1 time unit after the rising edge; outputs sampled on the falling edge.
    task automatic pre_half(input logic v, input logic [1:0] op, input int b, input logic [13:0] row);
        cmd_valid = v; cmd_op = op; cmd_bank = 3'(b); cmd_row = row;
        @(negedge clk);
        check_model();
    endtask

    task automatic post_half(input logic v, input logic [1:0] op, input int b, input logic [13:0] row);
        logic lg;
        lg = m_legal(op, b);
        @(posedge clk); #1;
        m_err = v & ~lg;
        if (v & lg) m_apply(op, b, row);
        cyc++;
    endtask

    task automatic cycle(input logic v, input logic [1:0] op, input int b, input logic [13:0] row);
        pre_half(v, op, b, row);
        post_half(v, op, b, row);
    endtask

    task automatic sync_reset();
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  op;
        int          b;
        logic [13:0] row;
        logic        e_legal;
        logic        e_err;
        int          w;
        logic [1:0]  e_st;
        logic        e_acc;
        logic [13:0] e_row;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int         r;
        logic       rv;
        logic [1:0] rop;

        tbl[0]  = '{1'b1, OP_ACT, 2, 14'h123, 1'b1, 1'b0, 2, S_IDLE, 1'b0, 14'h000};
        tbl[1]  = '{1'b0, OP_ACT, 2, 14'h000, 1'b0, 1'b0, 2, S_ACTG, 1'b0, 14'h123};
        tbl[2]  = '{1'b0, OP_ACT, 2, 14'h000, 1'b0, 1'b0, 2, S_ACTG, 1'b0, 14'h123};
        tbl[3]  = '{1'b0, OP_ACT, 2, 14'h000, 1'b0, 1'b0, 2, S_ACTG, 1'b0, 14'h123};
        tbl[4]  = '{1'b0, OP_PRE, 2, 14'h000, 1'b0, 1'b0, 2, S_ACT,  1'b1, 14'h123};
        tbl[5]  = '{1'b1, OP_PRE, 2, 14'h000, 1'b0, 1'b0, 2, S_ACT,  1'b1, 14'h123};
        tbl[6]  = '{1'b0, OP_PRE, 2, 14'h000, 1'b0, 1'b1, 2, S_ACT,  1'b1, 14'h123};
        tbl[7]  = '{1'b0, OP_PRE, 2, 14'h000, 1'b0, 1'b0, 2, S_ACT,  1'b1, 14'h123};
        tbl[8]  = '{1'b1, OP_PRE, 2, 14'h000, 1'b1, 1'b0, 2, S_ACT,  1'b1, 14'h123};
        tbl[9]  = '{1'b0, OP_ACT, 2, 14'h000, 1'b0, 1'b0, 2, S_PRE,  1'b0, 14'h123};
        tbl[10] = '{1'b0, OP_ACT, 2, 14'h000, 1'b0, 1'b0, 2, S_PRE,  1'b0, 14'h123};
        tbl[11] = '{1'b0, OP_ACT, 2, 14'h000, 1'b1, 1'b0, 2, S_IDLE, 1'b0, 14'h123};
        tbl[12] = '{1'b1, OP_ACT, 0, 14'h055, 1'b1, 1'b0, 0, S_IDLE, 1'b0, 14'h000};
        tbl[13] = '{1'b1, OP_ACT, 1, 14'h2AB, 1'b0, 1'b0, 1, S_IDLE, 1'b0, 14'h000};
        tbl[14] = '{1'b1, OP_ACT, 1, 14'h2AB, 1'b1, 1'b1, 1, S_IDLE, 1'b0, 14'h000};
        tbl[15] = '{1'b0, OP_ACT, 1, 14'h000, 1'b0, 1'b0, 1, S_ACTG, 1'b0, 14'h2AB};

        cmd_valid = 1'b0; cmd_op = OP_ACT; cmd_bank = '0; cmd_row = '0;
        rst = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        pre_half(1'b0, OP_ACT, 0, 14'h0);
        chk("rst_can_activate", can_activate, 8'hFF);
        chk("rst_can_access", can_access, 8'h00);
        post_half(1'b0, OP_ACT, 0, 14'h0);

        // Directed table: ACT/PRE timing on b2, tRRD on b0/b1
        for (int i = 0; i < 16; i++) begin
            pre_half(tbl[i].v, tbl[i].op, tbl[i].b, tbl[i].row);
            chk($sformatf("t%0d_legal", i), cmd_legal, tbl[i].e_legal);
            chk($sformatf("t%0d_err", i), cmd_err, tbl[i].e_err);
            chk($sformatf("t%0d_state", i), bank_state[tbl[i].w], tbl[i].e_st);
            chk($sformatf("t%0d_access", i), can_access[tbl[i].w], tbl[i].e_acc);
            chk($sformatf("t%0d_row", i), open_row[tbl[i].w], tbl[i].e_row);
            post_half(tbl[i].v, tbl[i].op, tbl[i].b, tbl[i].row);
        end

        // Asynchronous reset mid-ACTIVATING with an error pulse pending
        cycle(1'b1, OP_PRE, 1, 14'h0);
        chk("err_before_rst", cmd_err, 1'b1);
        cmd_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("arst_state", bank_state, 16'h0000);
        chk("arst_can_activate", can_activate, 8'hFF);
        chk("arst_can_access", can_access, 8'h00);
        chk("arst_can_precharge", can_precharge, 8'h00);
        chk("arst_err", cmd_err, 1'b0);
        chk("arst_open_row", open_row, 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        cycle(1'b0, OP_ACT, 0, 14'h0);

        // PREA with b0 and b5 open past tRAS
        cycle(1'b1, OP_ACT, 0, 14'h011);
        cycle(1'b0, OP_ACT, 0, 14'h0);
        cycle(1'b1, OP_ACT, 5, 14'h055);
        repeat (7) cycle(1'b0, OP_PREA, 0, 14'h0);
        pre_half(1'b1, OP_PREA, 0, 14'h0);
        chk("prea_legal", cmd_legal, 1'b1);
        chk("prea_before", bank_state, 16'h0802);
        post_half(1'b1, OP_PREA, 0, 14'h0);
        pre_half(1'b0, OP_ACT, 3, 14'h0);
        chk("prea_pc1", bank_state, 16'h0C03);
        post_half(1'b0, OP_ACT, 3, 14'h0);
        pre_half(1'b0, OP_ACT, 3, 14'h0);
        chk("prea_pc2", bank_state, 16'h0C03);
        post_half(1'b0, OP_ACT, 3, 14'h0);
        pre_half(1'b1, OP_ACT, 3, 14'h333);
        chk("prea_idle", bank_state, 16'h0000);
        chk("prea_act_b3", cmd_legal, 1'b1);
        post_half(1'b1, OP_ACT, 3, 14'h333);
        pre_half(1'b1, OP_PREA, 0, 14'h0);
        chk("prea_busy_legal", cmd_legal, 1'b0);
        post_half(1'b1, OP_PREA, 0, 14'h0);
        pre_half(1'b0, OP_ACT, 0, 14'h0);
        chk("prea_busy_err", cmd_err, 1'b1);
        post_half(1'b0, OP_ACT, 0, 14'h0);

        // REF with all banks idle
        sync_reset();
`ifdef SDRAM_BANK_REFRESH_EN
        pre_half(1'b1, OP_REF, 0, 14'h0);
        chk("ref_legal", cmd_legal, 1'b1);
        post_half(1'b1, OP_REF, 0, 14'h0);
        for (int k = 1; k < T_RFC; k++) begin
            pre_half(k == 3, OP_ACT, 4, 14'h044);
            chk($sformatf("ref_busy%0d", k), bank_state, 16'hFFFF);
            chk($sformatf("ref_can_act%0d", k), can_activate, 8'h00);
            if (k == 4) chk("ref_act_err", cmd_err, 1'b1);
            post_half(k == 3, OP_ACT, 4, 14'h044);
        end
        pre_half(1'b0, OP_ACT, 0, 14'h0);
        chk("ref_done", bank_state, 16'h0000);
        post_half(1'b0, OP_ACT, 0, 14'h0);
`else
        pre_half(1'b1, OP_REF, 0, 14'h0);
        chk("ref_legal", cmd_legal, 1'b0);
        post_half(1'b1, OP_REF, 0, 14'h0);
        pre_half(1'b0, OP_ACT, 0, 14'h0);
        chk("ref_err", cmd_err, 1'b1);
        chk("ref_state", bank_state, 16'h0000);
        post_half(1'b0, OP_ACT, 0, 14'h0);
`endif

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45)      rop = OP_ACT;
            else if (r < 80) rop = OP_PRE;
            else if (r < 93) rop = OP_PREA;
            else             rop = OP_REF;
            rv = ($urandom_range(0, 3) != 0);
            cycle(rv, rop, int'($urandom_range(0, NB - 1)), 14'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
